intr_pending_arbiter: RTL
=========================

Name: intr_pending_arbiter

Overview:
- Front-end scheduler for the interrupt path.
- Captures rising edges on raw peripheral interrupt lines into pending bits and applies a per-source mask.
- Picks one winner by programmable priority, with round-robin tie-break among equal priorities.
- Sequences a present/ack/done handshake with the CPU. Priorities, mask and pending state are accessed over the same simple APB-style port used elsewhere in the interrupt subsystem.

Parameters:
- NUM_INTR, 16, number of interrupt sources.
- WIDTH, $clog2(NUM_INTR), width of a source ID and of a priority value.
- ADDR_W, WIDTH+2, APB address width.

Ports:
- pclk_i  input  1  clock; all state changes on rising edge.
- prst_n_i  input  1  reset; asynchronous assert, active-low.
- penable_i  input  1  APB access strobe.
- pwrite_i  input  1  1=write, 0=read.
- paddr_i  input  ADDR_W  register address.
- pwdata_i  input  NUM_INTR  write data.
- prdata_o  output  NUM_INTR  registered read data.
- pready_o  output  1  registered access-complete.
- irq_i  input  NUM_INTR  raw level interrupt lines, synchronous to pclk_i.
- intr_valid_o  output  1  winner presented to CPU.
- intr_id_o  output  WIDTH  presented source ID.
- intr_ack_i  input  1  CPU accepts presented ID.
- intr_done_i  input  1  CPU finished servicing.

Behaviour:
- Reset values (prst_n_i=0, asynchronous):
  - pready_o=0, prdata_o=0, intr_valid_o=0, intr_id_o=0.
  - All priorities 0, mask all 1s (all sources masked), pending 0, irq_q 0, last_served=NUM_INTR-1, state IDLE.
- Register map:
  - addr 0..NUM_INTR-1: priority[addr]. Low WIDTH bits are used; upper write bits are ignored; reads are zero-extended.
  - addr NUM_INTR: mask. 1=masked.
  - addr NUM_INTR+1: pending. Read returns the bits; a write is write-1-to-clear.
  - addr NUM_INTR+2: status, read-only. Bits[1:0]=state, bits[WIDTH+1:2]=last_served.
  - Any other address: reads 0, writes ignored.
- APB timing:
  - On a penable_i cycle, pready_o=1 at the next edge, and prdata_o is updated at that edge for reads.
  - When penable_i=0, pready_o=0 at the next edge.
  - Write data takes effect at that same edge.
- Edge capture:
  - irq_q <= irq_i every cycle.
  - rise = irq_i & ~irq_q; a rise sets pending at the next edge.
  - A source whose line is high out of reset records no edge until it falls and rises again.
- Pending priority per bit, highest first:
  1. set by rise
  2. clear by ack of that ID
  3. APB W1C
  - Exception: APB W1C of the currently presented ID while in PRESENT is ignored.
- eligible = pending & ~mask.
- State machine (encoded IDLE=0, ARB=1, PRESENT=2, SERVICE=3):
  - IDLE: if eligible!=0, go to ARB; otherwise stay.
  - ARB, one cycle:
    - If eligible==0 (cleared meanwhile), return to IDLE.
    - Otherwise the winner is the eligible source with the highest priority value.
    - Ties go to the first eligible ID at or after (last_served+1) mod NUM_INTR, scanning upward with wrap.
    - Register intr_id_o=winner, set intr_valid_o=1, go to PRESENT.
  - PRESENT:
    - Hold intr_valid_o and intr_id_o stable until intr_ack_i=1.
    - Mask or priority changes do not retract the presented ID.
    - On ack: clear pending[id] (unless a simultaneous rise on that ID), set intr_valid_o=0, go to SERVICE.
    - intr_done_i is ignored in this state.
  - SERVICE:
    - Wait for intr_done_i=1. Then last_served<=intr_id_o and intr_id_o<=0.
    - Go to ARB if eligible (excluding the just-served bit unless it was re-set) is nonzero; otherwise go to IDLE.
    - intr_ack_i is ignored in this state.
- Latency:
  - irq_i rising at edge n sets pending at n+1.
  - From an IDLE start, intr_valid_o=1 at edge n+3.
- Reset mid-operation: immediately returns to the reset values; any in-flight presentation is dropped without handshake.

Test Plan:
- Reset, unmask all (write addr 16 = 0x0000), priority[3]=5, priority[9]=2; pulse irq_i[3] and irq_i[9] high in the same cycle -> intr_valid_o=1, intr_id_o=3 three edges later. After ack and done, ID 9 is presented next; pending reads 0 at the end.
- All priorities 0; raise irq_i[2], [5] and [14] together -> service order 2, 5, 14. Raise [2] and [5] again (last_served=14) -> order 2, 5. With last_served=2, raise [2] and [5] -> 5 first.
- mask=0xFFFF; raise irq_i[7] -> no intr_valid_o, pending reads 0x0080. Write mask=0xFF7F -> ID 7 presented.
- While ID 4 is presented, write 1 to pending bit 4 and raise irq_i[4] again during the ack cycle -> presentation is held and pending[4] stays 1 after ack, so ID 4 is re-presented after done.
- Hold irq_i[1] high through reset release -> no pending. Drop and re-raise it -> pending[1]=1.
- Assert prst_n_i=0 while in PRESENT -> intr_valid_o=0 and prdata_o=0 asynchronously, and the status read after reset returns 0x003C (IDLE, last_served=15).

Source files
------------

// File: rtl/intr_pending_arbiter_if.sv
// Bus bundle for intr_pending_arbiter: APB-style register access plus
// the present/ack/done interrupt handshake with the CPU.
interface intr_pending_arbiter_if #(
  parameter int NUM_INTR = 16,
  parameter int WIDTH    = $clog2(NUM_INTR),
  parameter int ADDR_W   = WIDTH + 2
);
  logic                penable_i;
  logic                pwrite_i;
  logic [ADDR_W-1:0]   paddr_i;
  logic [NUM_INTR-1:0] pwdata_i;
  logic [NUM_INTR-1:0] prdata_o;
  logic                pready_o;
  logic                intr_valid_o;
  logic [WIDTH-1:0]    intr_id_o;
  logic                intr_ack_i;
  logic                intr_done_i;

  modport master (
    output penable_i, pwrite_i, paddr_i, pwdata_i, intr_ack_i, intr_done_i,
    input  prdata_o, pready_o, intr_valid_o, intr_id_o
  );

  modport slave (
    input  penable_i, pwrite_i, paddr_i, pwdata_i, intr_ack_i, intr_done_i,
    output prdata_o, pready_o, intr_valid_o, intr_id_o
  );
endinterface

// File: rtl/intr_pending_arbiter.sv
// Interrupt front-end: rising-edge capture into pending bits, per-source mask,
// priority arbitration with round-robin tie-break and a present/ack/done handshake.
module intr_pending_arbiter #(
  parameter int NUM_INTR = 16,
  parameter int WIDTH    = $clog2(NUM_INTR),
  parameter int ADDR_W   = WIDTH + 2
) (
  input  logic                pclk_i,
  input  logic                prst_n_i,
  input  logic [NUM_INTR-1:0] irq_i,
  intr_pending_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_PRESENT = 2'd2,
    ST_SERVICE = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(NUM_INTR);
  localparam logic [ADDR_W-1:0] ADDR_PEND = ADDR_W'(NUM_INTR + 1);
  localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(NUM_INTR + 2);

  state_e              state_r, state_nxt_s;
  logic [NUM_INTR-1:0] irq_q_r, pend_r, mask_r;
  logic                edge_en_r;
  logic [WIDTH-1:0]    prio_r [NUM_INTR];
  logic [WIDTH-1:0]    last_served_r, last_served_nxt_s;
  logic [WIDTH-1:0]    intr_id_r, intr_id_nxt_s;
  logic                intr_valid_r, intr_valid_nxt_s;
  logic [NUM_INTR-1:0] prdata_r, rdata_s;
  logic                pready_r;

  logic                wr_s, rd_s;
  logic [NUM_INTR-1:0] rise_s, eligible_s, pend_nxt_s, w1c_s, id_onehot_s, hold_s, ack_clr_s;
  logic                win_found_s, take_s;
  logic [WIDTH-1:0]    win_id_s, win_prio_s, idx_s;
  logic [WIDTH:0]      sum_s;

  assign wr_s        = bus.penable_i & bus.pwrite_i;
  assign rd_s        = bus.penable_i & ~bus.pwrite_i;
  // edge_en_r keeps a line that is already high at reset release from counting as a rise
  assign rise_s      = irq_i & ~irq_q_r & {NUM_INTR{edge_en_r}};
  assign eligible_s  = pend_r & ~mask_r;
  assign id_onehot_s = {{(NUM_INTR-1){1'b0}}, 1'b1} << intr_id_r;
  assign hold_s      = (state_r == ST_PRESENT) ? id_onehot_s : {NUM_INTR{1'b0}};
  assign ack_clr_s   = (state_r == ST_PRESENT && bus.intr_ack_i) ? id_onehot_s : {NUM_INTR{1'b0}};
  assign w1c_s       = (wr_s && bus.paddr_i == ADDR_PEND) ? (bus.pwdata_i & ~hold_s) : {NUM_INTR{1'b0}};
  assign pend_nxt_s  = (pend_r & ~w1c_s & ~ack_clr_s) | rise_s;

  assign bus.prdata_o     = prdata_r;
  assign bus.pready_o     = pready_r;
  assign bus.intr_valid_o = intr_valid_r;
  assign bus.intr_id_o    = intr_id_r;

  // Register read mux
  always_comb begin
    rdata_s = {NUM_INTR{1'b0}};
    if (bus.paddr_i < ADDR_MASK) begin
      rdata_s = NUM_INTR'(prio_r[bus.paddr_i[WIDTH-1:0]]);
    end else if (bus.paddr_i == ADDR_MASK) begin
      rdata_s = mask_r;
    end else if (bus.paddr_i == ADDR_PEND) begin
      rdata_s = pend_r;
    end else if (bus.paddr_i == ADDR_STAT) begin
      rdata_s = NUM_INTR'({last_served_r, 2'(state_r)});
    end else begin
      rdata_s = {NUM_INTR{1'b0}};
    end
  end

  // Winner search: scan upward from last_served+1; strict '>' keeps the first of equal priorities
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {WIDTH{1'b0}};
    win_prio_s  = {WIDTH{1'b0}};
    sum_s       = {(WIDTH+1){1'b0}};
    idx_s       = {WIDTH{1'b0}};
    take_s      = 1'b0;
    for (int k = 0; k < NUM_INTR; k++) begin
      sum_s       = {1'b0, last_served_r} + (WIDTH+1)'(k) + {{WIDTH{1'b0}}, 1'b1};
      idx_s       = (sum_s >= (WIDTH+1)'(NUM_INTR)) ? WIDTH'(sum_s - (WIDTH+1)'(NUM_INTR))
                                                    : sum_s[WIDTH-1:0];
      take_s      = eligible_s[idx_s] && (!win_found_s || prio_r[idx_s] > win_prio_s);
      win_id_s    = take_s ? idx_s : win_id_s;
      win_prio_s  = take_s ? prio_r[idx_s] : win_prio_s;
      win_found_s = win_found_s | take_s;
    end
  end

  // Handshake FSM next-state and output decode
  always_comb begin
    state_nxt_s       = state_r;
    intr_valid_nxt_s  = intr_valid_r;
    intr_id_nxt_s     = intr_id_r;
    last_served_nxt_s = last_served_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = (eligible_s != {NUM_INTR{1'b0}}) ? ST_ARB : ST_IDLE;
      end
      ST_ARB: begin
        if (win_found_s) begin
          intr_id_nxt_s    = win_id_s;
          intr_valid_nxt_s = 1'b1;
          state_nxt_s      = ST_PRESENT;
        end else begin
          state_nxt_s      = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (bus.intr_ack_i) begin
          intr_valid_nxt_s = 1'b0;
          state_nxt_s      = ST_SERVICE;
        end else begin
          state_nxt_s      = ST_PRESENT;
        end
      end
      ST_SERVICE: begin
        // pend_r[id] was cleared at ack, so it only counts here if re-set by a new rise
        if (bus.intr_done_i) begin
          last_served_nxt_s = intr_id_r;
          intr_id_nxt_s     = {WIDTH{1'b0}};
          state_nxt_s       = (eligible_s != {NUM_INTR{1'b0}}) ? ST_ARB : ST_IDLE;
        end else begin
          state_nxt_s       = ST_SERVICE;
        end
      end
      default: begin
        state_nxt_s      = ST_IDLE;
        intr_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM and handshake output registers
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_r       <= ST_IDLE;
      intr_valid_r  <= 1'b0;
      intr_id_r     <= {WIDTH{1'b0}};
      last_served_r <= WIDTH'(NUM_INTR - 1);
    end else begin
      state_r       <= state_nxt_s;
      intr_valid_r  <= intr_valid_nxt_s;
      intr_id_r     <= intr_id_nxt_s;
      last_served_r <= last_served_nxt_s;
    end
  end

  // Edge capture and pending bits
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      irq_q_r   <= {NUM_INTR{1'b0}};
      edge_en_r <= 1'b0;
      pend_r    <= {NUM_INTR{1'b0}};
    end else begin
      irq_q_r   <= irq_i;
      edge_en_r <= 1'b1;
      pend_r    <= pend_nxt_s;
    end
  end

  // Configuration registers and APB response
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      for (int i = 0; i < NUM_INTR; i++) prio_r[i] <= {WIDTH{1'b0}};
      mask_r   <= {NUM_INTR{1'b1}};
      prdata_r <= {NUM_INTR{1'b0}};
      pready_r <= 1'b0;
    end else begin
      pready_r <= bus.penable_i;
      if (rd_s) prdata_r <= rdata_s;
      if (wr_s && bus.paddr_i < ADDR_MASK) prio_r[bus.paddr_i[WIDTH-1:0]] <= bus.pwdata_i[WIDTH-1:0];
      if (wr_s && bus.paddr_i == ADDR_MASK) mask_r <= bus.pwdata_i;
    end
  end

endmodule
